// File: rtl/midi_sysex_tx.sv
// SysEx patch-dump framer: reads dump_len bytes from patch memory and streams
// F0 / ID / DEV / CMD / ADDR / data / checksum / F7 over a valid/ready link.
module midi_sysex_tx #(
   parameter logic [7:0] MANUF_ID = 8'h7D,
   parameter logic [7:0] CMD_DUMP = 8'h12,
   parameter int         ADDR_W   = 7
) (
   input  logic              reg_clk,
   input  logic              reset_reg,
   input  logic [3:0]        midi_ch,
   input  logic              dump_req,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [7:0]        dump_len,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_data,
   output logic [7:0]        tx_byte,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR,
      S_ADDR,
      S_FETCH,
      S_LATCH,
      S_DATA,
      S_CSUM,
      S_EOX,
      S_DONE
   } state_t;

   state_t              state_q,    state_d;
   logic [1:0]          hdr_idx_q,  hdr_idx_d;
   logic [3:0]          ch_q,       ch_d;
   logic [ADDR_W-1:0]   addr_q,     addr_d;
   logic [7:0]          cnt_q,      cnt_d;
   logic [6:0]          sum_q,      sum_d;
   logic [7:0]          tx_byte_q,  tx_byte_d;
   logic                tx_valid_q, tx_valid_d;
   logic                mem_rd_q,   mem_rd_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                busy_q,     busy_d;
   logic                done_q,     done_d;

   logic                xfer;

   assign xfer = tx_valid_q & tx_ready;

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves one unassigned (no latches).
      state_d    = state_q;
      hdr_idx_d  = hdr_idx_q;
      ch_d       = ch_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      sum_d      = sum_q;
      tx_byte_d  = tx_byte_q;
      tx_valid_d = tx_valid_q;
      mem_rd_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (dump_req && (dump_len != 8'd0)) begin
               state_d    = S_HDR;
               hdr_idx_d  = 2'd0;
               ch_d       = midi_ch;
               addr_d     = start_addr;
               cnt_d      = dump_len;
               sum_d      = 7'(start_addr);
               tx_byte_d  = 8'hF0;
               tx_valid_d = 1'b1;
               busy_d     = 1'b1;
            end
         end

         S_HDR: begin
            if (xfer) begin
               hdr_idx_d = hdr_idx_q + 2'd1;
               case (hdr_idx_q)
                  2'd0:    tx_byte_d = MANUF_ID;
                  2'd1:    tx_byte_d = {4'h0, ch_q};
                  2'd2:    tx_byte_d = CMD_DUMP;
                  default: begin
                     tx_byte_d = {1'b0, 7'(addr_q)};
                     state_d   = S_ADDR;
                  end
               endcase
            end
         end

         S_ADDR: begin
            if (xfer) begin
               state_d    = S_FETCH;
               tx_valid_d = 1'b0;
               mem_rd_d   = 1'b1;
               mem_addr_d = addr_q;
               addr_d     = addr_q + ADDR_W'(1);
            end
         end

         S_FETCH: state_d = S_LATCH;

         // Read data is valid now, one cycle after the strobe.
         S_LATCH: begin
            state_d    = S_DATA;
            tx_byte_d  = mem_data & 8'h7F;
            tx_valid_d = 1'b1;
            sum_d      = 7'({1'b0, sum_q} + (mem_data & 8'h7F));
         end

         S_DATA: begin
            if (xfer) begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  state_d   = S_CSUM;
                  tx_byte_d = {1'b0, 7'h00 - sum_q};
               end else begin
                  state_d    = S_FETCH;
                  tx_valid_d = 1'b0;
                  mem_rd_d   = 1'b1;
                  mem_addr_d = addr_q;
                  addr_d     = addr_q + ADDR_W'(1);
               end
            end
         end

         S_CSUM: begin
            if (xfer) begin
               state_d   = S_EOX;
               tx_byte_d = 8'hF7;
            end
         end

         S_EOX: begin
            if (xfer) begin
               state_d    = S_DONE;
               tx_valid_d = 1'b0;
               busy_d     = 1'b0;
               done_d     = 1'b1;
            end
         end

         S_DONE: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge reg_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset_reg) begin
         state_q    <= S_IDLE;
         hdr_idx_q  <= 2'd0;
         ch_q       <= 4'd0;
         addr_q     <= '0;
         cnt_q      <= 8'd0;
         sum_q      <= 7'd0;
         tx_byte_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hdr_idx_q  <= hdr_idx_d;
         ch_q       <= ch_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         sum_q      <= sum_d;
         tx_byte_q  <= tx_byte_d;
         tx_valid_q <= tx_valid_d;
         mem_rd_q   <= mem_rd_d;
         mem_addr_q <= mem_addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign tx_byte  = tx_byte_q;
   assign tx_valid = tx_valid_q;
   assign mem_rd   = mem_rd_q;
   assign mem_addr = mem_addr_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_midi_sysex_tx.sv
// Directed bench for midi_sysex_tx: hand-computed frames, backpressure,
// ignored requests and mid-frame reset, checked on the falling clock edge.
`timescale 1ns/1ps
module tb_midi_sysex_tx;

   logic       reg_clk = 1'b0;
   logic       reset_reg;
   logic [3:0] midi_ch;
   logic       dump_req;
   logic [6:0] start_addr;
   logic [7:0] dump_len;
   logic       mem_rd;
   logic [6:0] mem_addr;
   logic [7:0] mem_data;
   logic [7:0] tx_byte;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [7:0] mem [128];
   logic [6:0] rd_log [$];
   logic [7:0] exp_q [$];

   midi_sysex_tx #(.MANUF_ID(8'h7D), .CMD_DUMP(8'h12), .ADDR_W(7)) dut (
      .reg_clk    (reg_clk),
      .reset_reg  (reset_reg),
      .midi_ch    (midi_ch),
      .dump_req   (dump_req),
      .start_addr (start_addr),
      .dump_len   (dump_len),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .tx_byte    (tx_byte),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 reg_clk = ~reg_clk;

   // Patch memory model: synchronous read, data valid the cycle after mem_rd.
   always @(posedge reg_clk) if (mem_rd) mem_data <= mem[mem_addr];

   always @(negedge reg_clk) if (mem_rd) rd_log.push_back(mem_addr);

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt = pass_cnt + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (tx_valid !== 1'b1 && n < 64) begin
         @(negedge reg_clk);
         n++;
      end
      if (n >= 64) check({tag, "_timeout"}, 32'(tx_valid), 32'd1);
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] exp);
      wait_valid(tag);
      check(tag, 32'(tx_byte), 32'(exp));
      @(negedge reg_clk);
   endtask

   task automatic expect_bytes(input string tag, input int first, input int last);
      for (int i = first; i <= last; i++)
         expect_byte($sformatf("%s_b%0d", tag, i), exp_q[i]);
   endtask

   task automatic start_dump(input string tag, input logic [3:0] ch,
                             input logic [6:0] addr, input logic [7:0] len);
      midi_ch    = ch;
      start_addr = addr;
      dump_len   = len;
      dump_req   = 1'b1;
      @(negedge reg_clk);
      dump_req   = 1'b0;
      check({tag, "_lat_busy"},  32'(busy),     32'd1);
      check({tag, "_lat_valid"}, 32'(tx_valid), 32'd1);
      check({tag, "_lat_f0"},    32'(tx_byte),  32'hF0);
   endtask

   task automatic check_done(input string tag);
      check({tag, "_done"},      32'(done), 32'd1);
      check({tag, "_busy_fall"}, 32'(busy), 32'd0);
      @(negedge reg_clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      logic quiet;
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      mem[7'h10] = 8'h05;
      mem[7'h11] = 8'h83;
      mem[7'h7F] = 8'h22;
      mem[7'h20] = 8'h40;
      mem_data   = 8'h00;

      reset_reg  = 1'b1;
      midi_ch    = 4'h0;
      dump_req   = 1'b0;
      start_addr = 7'h00;
      dump_len   = 8'd0;
      tx_ready   = 1'b1;
      repeat (2) @(negedge reg_clk);
      check("rst_valid",   32'(tx_valid), 32'd0);
      check("rst_byte",    32'(tx_byte),  32'h00);
      check("rst_mem_rd",  32'(mem_rd),   32'd0);
      check("rst_mem_adr", 32'(mem_addr), 32'd0);
      check("rst_busy",    32'(busy),     32'd0);
      check("rst_done",    32'(done),     32'd0);
      reset_reg = 1'b0;
      @(negedge reg_clk);

      // Basic frame: sum 10+05+03=18, csum 80-18=68.
      exp_q = '{8'hF0, 8'h7D, 8'h03, 8'h12, 8'h10, 8'h05, 8'h03, 8'h68, 8'hF7};
      rd_log.delete();
      start_dump("basic", 4'h3, 7'h10, 8'd2);
      expect_bytes("basic", 0, 4);
      check("basic_gap_valid", 32'(tx_valid), 32'd0);
      check("basic_gap_rd",    32'(mem_rd),   32'd1);
      check("basic_gap_addr",  32'(mem_addr), 32'h10);
      expect_bytes("basic", 5, 8);
      check_done("basic");
      check("basic_rd_count", 32'(rd_log.size()), 32'd2);

      // Zero checksum.
      exp_q = '{8'hF0, 8'h7D, 8'h0A, 8'h12, 8'h00, 8'h00, 8'h00, 8'hF7};
      start_dump("zero", 4'hA, 7'h00, 8'd1);
      expect_bytes("zero", 0, 7);
      check_done("zero");

      // Address wrap: 7F+22+00 = A1 -> 21 mod 128, csum 5F.
      exp_q = '{8'hF0, 8'h7D, 8'h01, 8'h12, 8'h7F, 8'h22, 8'h00, 8'h5F, 8'hF7};
      rd_log.delete();
      start_dump("wrap", 4'h1, 7'h7F, 8'd2);
      expect_bytes("wrap", 0, 8);
      check_done("wrap");
      check("wrap_rd_count", 32'(rd_log.size()), 32'd2);
      if (rd_log.size() == 2) begin
         check("wrap_rd0", 32'(rd_log[0]), 32'h7F);
         check("wrap_rd1", 32'(rd_log[1]), 32'h00);
      end

      // Backpressure on F0 and on the data byte: 20+40=60, csum 20.
      exp_q = '{8'hF0, 8'h7D, 8'h05, 8'h12, 8'h20, 8'h40, 8'h20, 8'hF7};
      tx_ready = 1'b0;
      start_dump("bp", 4'h5, 7'h20, 8'd1);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_hold_f0_v%0d", i), 32'(tx_valid), 32'd1);
         check($sformatf("bp_hold_f0_b%0d", i), 32'(tx_byte),  32'hF0);
         @(negedge reg_clk);
      end
      tx_ready = 1'b1;
      @(negedge reg_clk);
      check("bp_id_next", 32'(tx_byte), 32'h7D);
      expect_bytes("bp", 1, 4);
      tx_ready = 1'b0;
      wait_valid("bp_data");
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_hold_d_v%0d", i), 32'(tx_valid), 32'd1);
         check($sformatf("bp_hold_d_b%0d", i), 32'(tx_byte),  32'h40);
         @(negedge reg_clk);
      end
      tx_ready = 1'b1;
      expect_bytes("bp", 5, 7);
      check_done("bp");

      // dump_len = 0 is ignored.
      midi_ch  = 4'h4;
      dump_len = 8'd0;
      dump_req = 1'b1;
      @(negedge reg_clk);
      dump_req = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (busy !== 1'b0 || tx_valid !== 1'b0 || done !== 1'b0) quiet = 1'b0;
         @(negedge reg_clk);
      end
      check("len0_quiet", 32'(quiet), 32'd1);

      // dump_req while busy leaves the frame unchanged.
      exp_q = '{8'hF0, 8'h7D, 8'h02, 8'h12, 8'h10, 8'h05, 8'h03, 8'h68, 8'hF7};
      start_dump("busyreq", 4'h2, 7'h10, 8'd2);
      expect_bytes("busyreq", 0, 1);
      midi_ch    = 4'h9;
      start_addr = 7'h50;
      dump_len   = 8'd5;
      dump_req   = 1'b1;
      expect_bytes("busyreq", 2, 2);
      dump_req   = 1'b0;
      expect_bytes("busyreq", 3, 8);
      check_done("busyreq");
      quiet = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (busy !== 1'b0 || tx_valid !== 1'b0) quiet = 1'b0;
         @(negedge reg_clk);
      end
      check("busyreq_after_quiet", 32'(quiet), 32'd1);

      // Reset during the data phase, then a clean frame.
      exp_q = '{8'hF0, 8'h7D, 8'h03, 8'h12, 8'h10};
      start_dump("rstmid", 4'h3, 7'h10, 8'd2);
      expect_bytes("rstmid", 0, 4);
      check("rstmid_rd_before", 32'(mem_rd), 32'd1);
      reset_reg = 1'b1;
      @(negedge reg_clk);
      check("rstmid_valid", 32'(tx_valid), 32'd0);
      check("rstmid_busy",  32'(busy),     32'd0);
      check("rstmid_rd",    32'(mem_rd),   32'd0);
      reset_reg = 1'b0;
      @(negedge reg_clk);
      exp_q = '{8'hF0, 8'h7D, 8'h0A, 8'h12, 8'h00, 8'h00, 8'h00, 8'hF7};
      start_dump("clean", 4'hA, 7'h00, 8'd1);
      expect_bytes("clean", 0, 7);
      check_done("clean");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
